// File: rtl/matrix_coef_loader.sv
// Colour-matrix coefficient writer: takes nine two's-complement beats, converts to
// sign-magnitude in a shadow bank and applies the full set to the outputs on frame_start.
module matrix_coef_loader #(
    parameter int MSIZE = 8,
    parameter int UNITY = 1 << (MSIZE - 2)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [MSIZE-1:0] s_data,
    input  logic             s_last,
    input  logic             frame_start,
    output logic [MSIZE-1:0] M00,
    output logic [MSIZE-1:0] M01,
    output logic [MSIZE-1:0] M02,
    output logic [MSIZE-1:0] M10,
    output logic [MSIZE-1:0] M11,
    output logic [MSIZE-1:0] M12,
    output logic [MSIZE-1:0] M20,
    output logic [MSIZE-1:0] M21,
    output logic [MSIZE-1:0] M22,
    output logic             pending,
    output logic             coef_upd,
    output logic             err
);

    localparam logic [MSIZE-1:0] UNITY_SM = MSIZE'(UNITY);
    localparam logic [3:0]       LAST_IDX = 4'd8;

    typedef enum logic {
        LOAD = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       count;
    logic [3:0]       count_next;
    logic             beat;
    logic             frame_err;
    logic             store;
    logic             apply;
    logic [MSIZE-1:0] shadow [9];
    logic [MSIZE-1:0] active [9];

    // Most negative input has no positive counterpart; clamp to full-scale magnitude.
    function automatic logic [MSIZE-1:0] to_sign_mag(input logic [MSIZE-1:0] d);
        logic [MSIZE-2:0] mag;
        mag = ~d[MSIZE-2:0] + (MSIZE-1)'(1);
        if (!d[MSIZE-1])
            return {1'b0, d[MSIZE-2:0]};
        else if (d[MSIZE-2:0] == '0)
            return '1;
        else
            return {1'b1, mag};
    endfunction

    always_ff @(posedge clock) begin
        if (rst) begin
            state <= LOAD;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            LOAD: begin
                if (beat) begin
                    if (count == LAST_IDX) begin
                        count_next = '0;
                        if (s_last)
                            state_next = PEND;
                    end else if (s_last) begin
                        count_next = '0;
                    end else begin
                        count_next = count + 4'd1;
                    end
                end
            end
            PEND: begin
                if (frame_start)
                    state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    // A beat is a framing error when s_last disagrees with being the ninth beat.
    always_comb begin
        s_ready   = (state == LOAD);
        pending   = (state == PEND);
        beat      = s_valid && s_ready;
        frame_err = beat && ((count == LAST_IDX) != s_last);
        store     = beat && !frame_err;
        apply     = (state == PEND) && frame_start;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            for (int unsigned i = 0; i < 9; i++) begin
                shadow[i] <= '0;
                active[i] <= (i % 4 == 0) ? UNITY_SM : '0;
            end
            coef_upd <= 1'b0;
            err      <= 1'b0;
        end else begin
            coef_upd <= apply;
            err      <= frame_err;
            if (store)
                shadow[count] <= to_sign_mag(s_data);
            if (apply) begin
                for (int unsigned i = 0; i < 9; i++)
                    active[i] <= shadow[i];
            end
        end
    end

    assign M00 = active[0];
    assign M01 = active[1];
    assign M02 = active[2];
    assign M10 = active[3];
    assign M11 = active[4];
    assign M12 = active[5];
    assign M20 = active[6];
    assign M21 = active[7];
    assign M22 = active[8];

endmodule

// File: doc/matrix_coef_loader.md
Name: matrix_coef_loader

Overview:
- Writer side of the 3x3 colour-matrix coefficient interface.
- Accepts nine two's-complement coefficients over a valid/ready stream and converts each to the sign-magnitude format the matrix multiplier consumes: MSB is the sign, the lower MSIZE-1 bits are the magnitude.
- Holds the nine values in a shadow bank. The whole set is applied atomically to the active outputs on the next frame_start, so the multiplier never sees a mixed matrix mid-frame.

Parameters:
- MSIZE, 8: coefficient width, input and output.
- UNITY, 64 (1<<(MSIZE-2)): magnitude of the diagonal coefficients after reset (identity matrix).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  coefficient beat valid.
- s_ready  out  1  loader can accept a beat.
- s_data  in  MSIZE  coefficient, two's complement. Order: M00,M01,M02,M10,M11,M12,M20,M21,M22.
- s_last  in  1  marks the 9th beat of a set.
- frame_start  in  1  one-cycle pulse at frame boundary (vsync-derived).
- M00,M01,M02,M10,M11,M12,M20,M21,M22  out  MSIZE each  active coefficients, sign-magnitude, registered.
- pending  out  1  complete set waiting in shadow bank.
- coef_upd  out  1  one-cycle pulse: active bank updated this cycle.
- err  out  1  one-cycle pulse: framing error, partial set discarded.

Behaviour:
- Beat acceptance: a beat is accepted when s_valid && s_ready on a rising edge.
- Reset values:
  - M00, M11, M22 = UNITY (sign 0); all other coefficients = 0.
  - Shadow bank = 0, beat count = 0, state LOAD.
  - s_ready = 1, pending = 0, coef_upd = 0, err = 0.
- Conversion per accepted beat:
  - d >= 0: write {0, d[MSIZE-2:0]}.
  - d < 0: write {1, (-d)[MSIZE-2:0]}.
  - d = -2^(MSIZE-1) saturates to {1, all ones}, e.g. 8'h80 -> 8'hFF.
  - Result is written to the shadow slot indexed by the beat count (0..8).
- State LOAD:
  - s_ready = 1.
  - Accepted beat with count < 8 and s_last = 0: store, count++.
  - Accepted beat with count < 8 and s_last = 1: err pulses next cycle, count -> 0, shadow contents are don't-care, stay in LOAD.
  - Accepted beat with count = 8 and s_last = 0: err pulses, count -> 0, beat discarded, stay in LOAD.
  - Accepted beat with count = 8 and s_last = 1: store, count -> 0, go to PEND. pending = 1 from the next cycle.
- State PEND:
  - s_ready = 0; pending = 1.
  - On frame_start: all nine active outputs load the shadow bank in the same edge. coef_upd = 1 in the following cycle; pending -> 0; go to LOAD.
- Latency and boundary cases:
  - Beat to shadow: 1 cycle.
  - frame_start in PEND to new M outputs visible: 1 cycle. coef_upd is asserted in the same cycle the new M outputs are first visible.
  - frame_start in LOAD is ignored; a partial set is retained and loading continues.
  - frame_start in the same cycle the 9th beat is accepted is NOT applied; the set waits for the next frame_start.
  - Back-to-back sets: the next set can start the cycle after coef_upd.
  - Active outputs change only on reset or a PEND frame_start, never mid-frame.
- Reset mid-load or in PEND: the partial or pending set is discarded and the identity matrix is restored at once.
- err and coef_upd are never asserted together.

Test Plan:
1. After reset, with no stimulus → M00 = M11 = M22 = 8'h40, others 8'h00; s_ready = 1; pending = 0.
2. Stream 9 beats {1,2,3,4,5,6,7,8,9}, s_last on the 9th, then frame_start 5 cycles later → pending = 1 and s_ready = 0 during the gap. One cycle after frame_start: M00..M22 = 8'h01..8'h09, coef_upd = 1 for exactly one cycle.
3. Stream beats with s_data = 8'hFF (-1), 8'h80 (-128), 8'h7F, 8'h00, ... → after apply: M00 = 8'h81, M01 = 8'hFF (saturated), M02 = 8'h7F, M10 = 8'h00.
4. s_last asserted on the 4th beat → err pulses once; the active bank is unchanged across a later frame_start. A subsequent correct 9-beat set applies normally.
5. 9th beat accepted in the same cycle as frame_start → no coef_upd. The next frame_start applies the set; s_ready stays 0 in between.
6. rst asserted while in PEND with a non-identity set loaded → identity outputs, pending = 0, s_ready = 1 on the next cycle; a following frame_start produces no coef_upd.
